// File: rtl/mem_read_arbiter_if.sv
// Bundle of requester handshake, read-return and memory-port signals for mem_read_arbiter.
// master: the arbiter side; slave: the clients plus memory side.
interface mem_read_arbiter_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int LEN_W  = 4
);
   logic              req0;
   logic              req1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [LEN_W-1:0]  len0;
   logic [LEN_W-1:0]  len1;
   logic              gnt0;
   logic              gnt1;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              rd_id;
   logic              done0;
   logic              done1;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;

   modport master (
      input  req0, req1, addr0, addr1, len0, len1, mem_data,
      output gnt0, gnt1, rd_valid, rd_data, rd_id, done0, done1, mem_addr
   );

   modport slave (
      output req0, req1, addr0, addr1, len0, len1, mem_data,
      input  gnt0, gnt1, rd_valid, rd_data, rd_id, done0, done1, mem_addr
   );
endinterface

// File: rtl/mem_read_arbiter.sv
// Two-requester burst read controller for a 16 x 8 synchronous-read memory.
// Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module mem_read_arbiter #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int LEN_W  = 4
) (
   input logic                clk,
   input logic                rst,
   mem_read_arbiter_if.master bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] READ = 2'd1;
   localparam logic [1:0] LAST = 2'd2;

   logic [1:0]        state;
   logic [LEN_W-1:0]  count;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              owner;
   logic              gnt0_q;
   logic              gnt1_q;
   logic              rd_valid_q;
   logic              rd_id_q;
   logic              done0_q;
   logic              done1_q;
   logic [DATA_W-1:0] rd_word;

   logic              pick_valid;
   logic              pick;

`ifdef ARB_FIXED_PRIO_EN
   always_comb begin
      pick_valid = bus.req0 | bus.req1;
      pick       = ~bus.req0;
   end
`else
   logic last_served;

   // Pointer changes only when a burst completes, so an abandoned burst does not count as served.
   always_ff @(posedge clk) begin
      if (!rst)
         last_served <= 1'b1;
      else if (state == LAST)
         last_served <= owner;
   end

   always_comb begin
      pick_valid = bus.req0 | bus.req1;
      if (bus.req0 && bus.req1)
         pick = ~last_served;
      else
         pick = ~bus.req0;
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         count      <= '0;
         mem_addr_q <= '0;
         owner      <= 1'b0;
         gnt0_q     <= 1'b0;
         gnt1_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_id_q    <= 1'b0;
         done0_q    <= 1'b0;
         done1_q    <= 1'b0;
      end else begin
         // Every READ cycle presents an address, whose word lands one cycle later.
         rd_valid_q <= (state == READ);
         done0_q    <= (state == READ) && (count == '0) && !owner;
         done1_q    <= (state == READ) && (count == '0) && owner;
         if (state == READ)
            rd_id_q <= owner;

         case (state)
            IDLE: begin
               if (pick_valid) begin
                  state      <= READ;
                  owner      <= pick;
                  gnt0_q     <= ~pick;
                  gnt1_q     <= pick;
                  mem_addr_q <= pick ? bus.addr1 : bus.addr0;
                  count      <= pick ? bus.len1 : bus.len0;
               end
            end
            READ: begin
               if (count == '0) begin
                  state <= LAST;
               end else begin
                  mem_addr_q <= mem_addr_q + ADDR_W'(1);
                  count      <= count - LEN_W'(1);
               end
            end
            LAST: begin
               state  <= IDLE;
               gnt0_q <= 1'b0;
               gnt1_q <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign rd_word      = rd_valid_q ? bus.mem_data : '0;

   assign bus.gnt0     = gnt0_q;
   assign bus.gnt1     = gnt1_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_word;
   assign bus.rd_id    = rd_id_q;
   assign bus.done0    = done0_q;
   assign bus.done1    = done1_q;
   assign bus.mem_addr = mem_addr_q;

endmodule

// File: doc/mem_read_arbiter.md
# mem_read_arbiter

Two-requester read controller for the 16 x 8 synchronous-read lookup memory. Accepts burst read requests (start address plus length), arbitrates between requester 0 and requester 1, sequences consecutive addresses into the memory with modulo-16 wrap-around, and returns each word with a valid strobe and requester ID. Sits between the memory's address/data port and the two client blocks; it is the only driver of the memory address.

## Interface
- ADDR_W, 4, memory address width (depth 2^ADDR_W = 16)
- DATA_W, 8, memory word width
- LEN_W, 4, burst length field width; a burst moves len+1 words (1..16)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset (rst = 0 resets on the next rising edge of clk)
- req0, req1  in  1  read request from requester 0 / 1; level, held until the matching gnt
- addr0, addr1  in  ADDR_W  burst start address, sampled at the acceptance edge
- len0, len1  in  LEN_W  burst length minus one, sampled at the acceptance edge
- gnt0, gnt1  out  1  high for every cycle the burst of requester 0 / 1 owns the memory; never both high
- rd_valid  out  1  rd_data carries a word this cycle
- rd_data  out  DATA_W  returned word; 0 when rd_valid = 0
- rd_id  out  1  requester owning the current rd_data
- done0, done1  out  1  one-cycle pulse on the last word of the burst
- mem_addr  out  ADDR_W  memory read address
- mem_data  in  DATA_W  memory read data, valid one clk after mem_addr is presented

## Operation
- States: IDLE, READ, LAST.
- Reset: state = IDLE. gnt0, gnt1, rd_valid, rd_id, done0, done1, mem_addr, and the address and count registers are 0. The round-robin pointer is set to "last served = 1", so requester 0 wins the first tie. rst low mid-burst abandons the burst; no done pulse is issued and no further rd_valid is issued.
- IDLE: if exactly one req is high, that requester is accepted. If both are high, the requester not served last is accepted. On acceptance, the next state is READ with gnt asserted, mem_addr = addr, and count = len.
- READ: each cycle mem_addr <= mem_addr + 1 (wraps 15 -> 0) and count <= count - 1. When count = 0 at a clock edge, the next state is LAST and mem_addr holds.
- LAST: the final word returns. done for the owning requester pulses. gnt drops at the exit edge, the pointer updates to the served requester, and the state returns to IDLE.
- req is ignored outside IDLE. req still high on return to IDLE counts as a new request and goes through arbitration again.
- len = 0 gives a single word: one READ cycle, then LAST.
- rd_valid is registered: it is high in each cycle following a READ cycle. rd_id is registered alongside rd_valid. rd_data = mem_data when rd_valid = 1, else 0.

## Timing
- Request seen in IDLE at edge E: gnt and first mem_addr from E+1; first rd_valid at E+2.
- A burst of N = len+1 words keeps gnt high for N+1 cycles: N READ cycles plus one LAST cycle.
- rd_valid is high for N consecutive cycles, with no gaps.
- doneX coincides with the Nth rd_valid.
- Back-to-back bursts: one IDLE bubble cycle. The earliest next gnt comes 2 cycles after the previous done.
- Address wrap: start 14, len 3 issues addresses 14, 15, 0, 1.

## Configuration
- ARB_FIXED_PRIO_EN defined: arbitration is fixed priority, requester 0 always wins ties, and the round-robin pointer is not built.
- ARB_FIXED_PRIO_EN undefined (default): round-robin as described under Operation.
- All other behaviour is identical in both builds.

## Test plan
The bench memory model holds mem[i] = 8'hF0 ^ i.
- Reset hold: rst = 0 for 2 cycles with req0 = 1 -> all outputs stay 0 and no gnt. After rst = 1, the request is accepted on the next edge.
- Single word: req0, addr0 = 5, len0 = 0 -> gnt0 for 2 cycles, mem_addr = 5. One rd_valid with rd_data = 8'hF5 and rd_id = 0, with done0 in the same cycle.
- Wrap burst: req1, addr1 = 14, len1 = 3 -> rd_data sequence F E, F F, F 0, F 1 (i.e. 8'hFE, 8'hFF, 8'hF0, 8'hF1) on 4 consecutive cycles, rd_id = 1, done1 with 8'hF1.
- Tie, round-robin: req0 and req1 high together from reset with len = 1 each, both held -> order 0, 1, 0, 1. gnt0 and gnt1 are never high together, with one idle cycle between bursts. Under ARB_FIXED_PRIO_EN the order is 0, 0, 0.
- Mid-burst reset: req0, addr0 = 0, len0 = 15, then rst = 0 at the 6th rd_valid -> the next cycle shows rd_valid = 0, gnt0 = 0, and no done0.
- Request during burst: req1 rises while gnt0 burst (len 2) runs -> req1 is ignored until IDLE, then gnt1 is asserted 2 cycles after done0.
